// File: rtl/fx_ci_ctrl_pkg.sv
// Shared definitions for the f(x) custom-instruction controller:
// opcodes, controller state encoding and the fp32 zero constant.
package fx_pkg;

  typedef enum logic [1:0] {
    OP_EVAL = 2'd0,
    OP_ACC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_READ = 2'd3
  } fx_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fx_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fx_ci_ctrl_if.sv
// Nios II custom-instruction handshake between the CPU (master) and the
// f(x) controller (slave).
interface fx_ci_ctrl_if;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic        busy;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  done, result, busy
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output done, result, busy
  );
endinterface

// File: rtl/fx_lat_counter.sv
// Loadable down-counter timing the datapath latency window.
// Stops at zero; zero flag is combinational from the count.
module fx_lat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority over decrement; all updates gated by the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fx_ci_ctrl.sv
// Multi-cycle custom-instruction controller for the f(x) evaluator.
// Holds the datapath operands for the full latency window, samples the
// result, pulses done, and keeps an fp32 running sum for ACC/LOAD/READ.
module fx_ci_ctrl
  import fx_pkg::*;
#(
  parameter int FX_LATENCY = 40,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  fx_ci_ctrl_if.slave ci,
  output logic        err_overlap,
  output logic        fx_clk_en,
  output logic [31:0] fx_dataa,
  output logic [31:0] fx_datab,
  input  logic [31:0] fx_result
);

  fx_state_e   state;
  fx_op_e      op;
  logic [31:0] sum_reg;
  logic        cnt_load;
  logic        cnt_zero;
  logic        start_compute;

  assign start_compute = (state == IDLE) && ci.start &&
                         ((ci.n == OP_EVAL) || (ci.n == OP_ACC));
  assign cnt_load      = start_compute;
  assign fx_clk_en     = ci.clk_en && (state == RUN);

  fx_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .en       (ci.clk_en),
    .load     (cnt_load),
    .load_val (CNT_W'(FX_LATENCY - 1)),
    .dec      (state == RUN),
    .zero     (cnt_zero)
  );

  // Instruction sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= OP_EVAL;
      ci.done     <= 1'b0;
      ci.busy     <= 1'b0;
      ci.result   <= FP_ZERO;
      err_overlap <= 1'b0;
      sum_reg     <= FP_ZERO;
      fx_dataa    <= FP_ZERO;
      fx_datab    <= FP_ZERO;
    end else if (ci.clk_en) begin
      case (state)
        IDLE: begin
          if (ci.start) begin
            unique case (fx_op_e'(ci.n))
              OP_EVAL, OP_ACC: begin
                fx_dataa <= ci.dataa;
                fx_datab <= (ci.n == OP_ACC) ? sum_reg : ci.datab;
                op       <= fx_op_e'(ci.n);
                ci.busy  <= 1'b1;
                state    <= RUN;
              end
              OP_LOAD: begin
                sum_reg   <= ci.datab;
                ci.result <= ci.datab;
                ci.done   <= 1'b1;
                state     <= FIN;
              end
              OP_READ: begin
                ci.result <= sum_reg;
                ci.done   <= 1'b1;
                state     <= FIN;
              end
            endcase
          end
        end
        RUN: begin
          if (ci.start) begin
            err_overlap <= 1'b1;
          end
          if (cnt_zero) begin
            ci.result <= fx_result;
            if (op == OP_ACC) begin
              sum_reg <= fx_result;
            end
            ci.done <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          ci.done <= 1'b0;
          ci.busy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_ci_ctrl.sv
// Bench for fx_ci_ctrl with a stub datapath (integer add behind an
// enabled pipeline of FX_LATENCY-1 registers, valid in the FX_LATENCY-th
// enabled cycle after the operands settle).
module tb_fx_ci_ctrl;
  import fx_pkg::*;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_overlap;
  logic        fx_clk_en;
  logic [31:0] fx_dataa;
  logic [31:0] fx_datab;
  logic [31:0] fx_result;

  always #5 clk = ~clk;

  fx_ci_ctrl_if ci();

  fx_ci_ctrl #(
    .FX_LATENCY(L),
    .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ci          (ci),
    .err_overlap (err_overlap),
    .fx_clk_en   (fx_clk_en),
    .fx_dataa    (fx_dataa),
    .fx_datab    (fx_datab),
    .fx_result   (fx_result)
  );

  // Stub datapath
  logic [31:0] pipe [L-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L - 1; i++) pipe[i] <= '0;
    end else if (fx_clk_en) begin
      pipe[0] <= fx_dataa + fx_datab;
      for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fx_result = pipe[L-2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: remaining enabled edges until done, plus the
  // architectural sum and the value the accepted instruction will return.
  int          m_left   = 0;
  bit          m_done   = 0;
  bit          m_busy   = 0;
  bit          m_err    = 0;
  bit          m_acc    = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_sum    = '0;
  logic [31:0] m_fa     = '0;
  logic [31:0] m_fb     = '0;
  logic [31:0] m_pend   = '0;
  bit          chk_on   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_busy = 0; m_err = 0; m_acc = 0;
      m_result = '0; m_sum = '0; m_fa = '0; m_fb = '0;
    end else if (ci.clk_en) begin
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_left > 0) begin
        if (ci.start) m_err = 1;
        m_left--;
        if (m_left == 0) begin
          m_result = m_pend;
          if (m_acc) m_sum = m_pend;
          m_done = 1;
        end
      end else if (ci.start) begin
        if (ci.n == OP_EVAL || ci.n == OP_ACC) begin
          m_acc  = (ci.n == OP_ACC);
          m_fa   = ci.dataa;
          m_fb   = m_acc ? m_sum : ci.datab;
          m_pend = m_fa + m_fb;
          m_left = L;
          m_busy = 1;
        end else if (ci.n == OP_LOAD) begin
          m_sum    = ci.datab;
          m_result = ci.datab;
          m_done   = 1;
        end else begin
          m_result = m_sum;
          m_done   = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("done", ci.done, m_done);
      check("busy", ci.busy, m_busy);
      check("result", ci.result, m_result);
      check("err_overlap", err_overlap, m_err);
      check("fx_clk_en", fx_clk_en, ci.clk_en && (m_left > 0));
      check("fx_dataa", fx_dataa, m_fa);
      check("fx_datab", fx_datab, m_fb);
    end
  end

  // Issue one instruction, wait (bounded) for done, check latency and result
  // against hand-computed literals. Optional clk_en stall and overlapping start.
  task automatic run_op(input string name, input fx_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int stall_at, input int ovl_at);
    int k;
    @(negedge clk); #1;
    ci.start = 1'b1; ci.n = op; ci.dataa = a; ci.datab = b;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ci.done === 1'b1) break;
      #1;
      ci.start = (k == ovl_at);
      if (k == ovl_at) begin
        ci.n = OP_LOAD; ci.datab = 32'hDEAD_BEEF;
      end
      if (k == stall_at)     ci.clk_en = 1'b0;
      if (k == stall_at + 3) ci.clk_en = 1'b1;
    end
    check({name, " latency"}, k, exp_lat);
    check({name, " result"}, ci.result, exp_res);
    #1;
    ci.start = 1'b0;
    ci.clk_en = 1'b1;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    ci.clk_en = 1'b1; ci.start = 1'b0; ci.n = OP_EVAL; ci.dataa = '0; ci.datab = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk_on = 1;
    check("rst done", ci.done, 1'b0);
    check("rst busy", ci.busy, 1'b0);
    check("rst result", ci.result, 32'h0);
    check("rst err", err_overlap, 1'b0);
    check("rst fx_clk_en", fx_clk_en, 1'b0);
    run_op("read0", OP_READ, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 0);

    run_op("eval", OP_EVAL, 32'h3F80_0000, 32'h0000_0010, 32'h3F80_0010, 6, 0, 0);
    run_op("read_after_eval", OP_READ, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 0);

    run_op("load", OP_LOAD, 32'h0, 32'h4000_0000, 32'h4000_0000, 1, 0, 0);
    run_op("acc5", OP_ACC, 32'h5, 32'h0, 32'h4000_0005, 6, 0, 0);
    run_op("acc3", OP_ACC, 32'h3, 32'h0, 32'h4000_0008, 6, 0, 0);
    run_op("read_sum", OP_READ, 32'h0, 32'h0, 32'h4000_0008, 1, 0, 0);

    run_op("stall", OP_EVAL, 32'h1, 32'h2, 32'h0000_0003, 9, 2, 0);

    run_op("overlap", OP_EVAL, 32'd10, 32'd20, 32'd30, 6, 0, 2);
    check("overlap err set", err_overlap, 1'b1);
    run_op("read_after_overlap", OP_READ, 32'h0, 32'h0, 32'h4000_0008, 1, 0, 0);
    check("overlap err sticky", err_overlap, 1'b1);

    // Abort: reset lands in RUN cycle 3
    dones = 0;
    @(negedge clk); #1;
    ci.start = 1'b1; ci.n = OP_EVAL; ci.dataa = 32'd7; ci.datab = 32'd8;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ci.done === 1'b1) dones++;
      #1;
      if (k == 1) ci.start = 1'b0;
      if (k == 3) rst = 1'b1;
      if (k == 4) rst = 1'b0;
    end
    check("abort no done", dones, 0);
    check("abort err cleared", err_overlap, 1'b0);
    check("abort busy", ci.busy, 1'b0);
    run_op("read_after_abort", OP_READ, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 0);
    run_op("eval_after_abort", OP_EVAL, 32'd4, 32'd5, 32'd9, 6, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
